hmac_stream_arbiter: RTL and testbench

// - Shares one HMAC verify pipeline (duplicate FIFO -> hmac core + check_sha) between N host streams.
// - Arbitrates AXI4SR packets round-robin at packet granularity and forwards the granted packet unchanged.
// - Records grant order in an order FIFO and routes each 1-bit verify result back to its requester.
// - Sits between the per-requester host FIFOs and the shared verify datapath.

---
 rtl/hmac_arb_pkg.sv | 30 +++
 rtl/hmac_order_fifo.sv | 49 ++++
 rtl/hmac_stream_arbiter.sv | 156 +++++++++++++++
 tb/tb_hmac_stream_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmac_arb_pkg.sv
// Shared types and the round-robin helper for the HMAC stream arbiter.
// Supports up to eight requesters.
package hmac_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 8;

  // First set bit of req after 'last', wrapping modulo n; returns 'last' if none.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last, input int n);
    logic [2:0] pick;
    logic       found;
    int         cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = int'(last) + k;
      cand = (cand >= n) ? cand - n : cand;
      if ((k <= n) && !found && req[3'(cand)]) begin
        pick  = 3'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hmac_order_fifo.sv
// Synchronous FIFO holding the grant order of packets awaiting a verify result.
// Pointers carry one wrap bit so full and empty are distinguishable.
module hmac_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop in the same cycle both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write, no reset needed on the entries.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/hmac_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one HMAC verify pipeline between
// N_REQ host streams, with in-order routing of verify results back to requesters.
module hmac_stream_arbiter
  import hmac_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = 512,
  parameter int TID_W       = 6,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [N_REQ-1:0]            s_tvalid,
  output logic [N_REQ-1:0]            s_tready,
  input  logic [N_REQ*DATA_W-1:0]     s_tdata,
  input  logic [N_REQ*DATA_W/8-1:0]   s_tkeep,
  input  logic [N_REQ*TID_W-1:0]      s_tid,
  input  logic [N_REQ-1:0]            s_tlast,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic [DATA_W/8-1:0]         m_tkeep,
  output logic [TID_W-1:0]            m_tid,
  output logic                        m_tlast,
  input  logic                        vr_valid,
  output logic                        vr_ready,
  input  logic                        vr_data,
  output logic [N_REQ-1:0]            r_valid,
  input  logic [N_REQ-1:0]            r_ready,
  output logic [N_REQ-1:0]            r_data,
  output logic [31:0]                 pkt_cnt,
  output logic                        err_orphan
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int KW    = DATA_W / 8;

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] head;
  logic             grant_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  // Next requester in round-robin order and whether a grant fires this cycle.
  always_comb begin
    pick     = IDX_W'(rr_pick(8'(s_tvalid), 3'(last_grant), N_REQ));
    grant_en = (state == IDLE) && (|s_tvalid) && !fifo_full;
  end

  // Packet FSM: one IDLE bubble per packet, grant held until the tlast handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_en) begin
          state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (m_tvalid && m_tready && m_tlast) begin
          state_next = IDLE;
        end else begin
          state_next = BUSY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Zero-latency data mux from the granted requester.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tid    = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state == BUSY) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant == IDX_W'(i)) begin
          m_tvalid    = s_tvalid[i];
          m_tdata     = s_tdata[i*DATA_W +: DATA_W];
          m_tkeep     = s_tkeep[i*KW +: KW];
          m_tid       = s_tid[i*TID_W +: TID_W];
          m_tlast     = s_tlast[i];
          s_tready[i] = m_tready;
        end else begin
          s_tready[i] = 1'b0;
        end
      end
    end else begin
      m_tvalid = 1'b0;
    end
  end

  // Verify results go to the oldest outstanding requester; empty FIFO stalls the result.
  always_comb begin
    vr_ready = 1'b0;
    r_valid  = '0;
    r_data   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (head == IDX_W'(i)) begin
        r_valid[i] = vr_valid & ~fifo_empty;
        r_data[i]  = vr_data;
        vr_ready   = r_ready[i] & ~fifo_empty;
      end else begin
        r_valid[i] = 1'b0;
        r_data[i]  = 1'b0;
      end
    end
    pop = vr_valid & vr_ready;
  end

  // State, grant bookkeeping, packet counter and sticky orphan flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      pkt_cnt    <= 32'd0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_en) begin
        grant      <= pick;
        last_grant <= pick;
        pkt_cnt    <= pkt_cnt + 32'd1;
      end
      if (vr_valid && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

  hmac_order_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (grant_en),
    .push_data (pick),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_hmac_stream_arbiter.sv
// Randomized bench for hmac_stream_arbiter against a packet/queue level reference model.
module tb_hmac_stream_arbiter;

  localparam int N     = 2;
  localparam int DW    = 64;
  localparam int KW    = DW / 8;
  localparam int TW    = 6;
  localparam int DEPTH = 8;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [TW-1:0] id;
    logic          l;
  } beat_t;

  logic            aclk = 1'b0;
  logic            areset = 1'b0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N*KW-1:0] s_tkeep = '0;
  logic [N*TW-1:0] s_tid = '0;
  logic [N-1:0]    s_tlast = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [TW-1:0]   m_tid;
  logic            m_tlast;
  logic            vr_valid = 1'b0;
  logic            vr_ready;
  logic            vr_data = 1'b0;
  logic [N-1:0]    r_valid;
  logic [N-1:0]    r_ready = '0;
  logic [N-1:0]    r_data;
  logic [31:0]     pkt_cnt;
  logic            err_orphan;

  hmac_stream_arbiter #(.N_REQ(N), .DATA_W(DW), .TID_W(TW), .ORDER_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tid(s_tid), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tid(m_tid), .m_tlast(m_tlast),
    .vr_valid(vr_valid), .vr_ready(vr_ready), .vr_data(vr_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .pkt_cnt(pkt_cnt), .err_orphan(err_orphan)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending beats per requester, outstanding grant order, counters.
  beat_t       src [N][$];
  int          ordq[$];
  bit          script[$];
  int          own_log[$];
  int          res_log[$];
  bit          busy_m;
  bit          fb_m;
  int          owner_m;
  int          last_m;
  logic [31:0] pkt_m;
  bit          orph_m;

  int p_valid = 100, p_mready = 100, p_rready = 100, p_vr = 0;
  bit allow_orphan = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic add_pkt(input int i, input int beats);
    beat_t b;
    for (int n = 0; n < beats; n++) begin
      b.d  = {$urandom, $urandom};
      b.k  = KW'($urandom);
      b.id = TW'(i * 16 + n);
      b.l  = (n == beats - 1);
      src[i].push_back(b);
    end
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    s_tvalid = '1;
    m_tready = 1'b1;
    vr_valid = 1'b1;
    r_ready  = '1;
    #1;
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_vr_ready", 64'(vr_ready), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    @(posedge aclk);
    #1;
    areset   = 1'b0;
    s_tvalid = '0;
    vr_valid = 1'b0;
    busy_m   = 1'b0;
    fb_m     = 1'b0;
    owner_m  = 0;
    last_m   = N - 1;
    pkt_m    = 32'd0;
    orph_m   = 1'b0;
    ordq.delete();
    script.delete();
    for (int i = 0; i < N; i++) src[i].delete();
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle();
    logic [N-1:0] v, exp_tr, exp_rv, rr;
    logic         vv, vd, exp_mv, exp_vr, hs, lastb;
    int           g, head;
    beat_t        b;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (src[i].size() > 0) begin
        b = src[i][0];
        v[i] = ($urandom_range(99) < p_valid);
      end else begin
        b = '{d: '0, k: '0, id: '0, l: 1'b0};
      end
      s_tdata[i*DW +: DW] = b.d;
      s_tkeep[i*KW +: KW] = b.k;
      s_tid[i*TW +: TW]   = b.id;
      s_tlast[i]          = b.l;
    end
    s_tvalid = v;
    m_tready = ($urandom_range(99) < p_mready);
    for (int i = 0; i < N; i++) rr[i] = ($urandom_range(99) < p_rready);
    r_ready = rr;
    if (script.size() > 0) begin
      vv = 1'b1;
      vd = script[0];
    end else if (ordq.size() > 0 || allow_orphan) begin
      vv = ($urandom_range(99) < p_vr);
      vd = 1'($urandom);
    end else begin
      vv = 1'b0;
      vd = 1'b0;
    end
    vr_valid = vv;
    vr_data  = vd;
    #1;
    exp_tr = '0;
    exp_mv = 1'b0;
    if (busy_m) begin
      exp_mv          = v[owner_m];
      exp_tr[owner_m] = m_tready;
    end
    check("s_tready", 64'(s_tready), 64'(exp_tr));
    check("m_tvalid", 64'(m_tvalid), 64'(exp_mv));
    if (exp_mv) begin
      b = src[owner_m][0];
      check("m_tdata", 64'(m_tdata), 64'(b.d));
      check("m_tkeep", 64'(m_tkeep), 64'(b.k));
      check("m_tid", 64'(m_tid), 64'(b.id));
      check("m_tlast", 64'(m_tlast), 64'(b.l));
    end
    head   = (ordq.size() > 0) ? ordq[0] : 0;
    exp_vr = (ordq.size() > 0) && rr[head];
    exp_rv = '0;
    if (ordq.size() > 0 && vv) exp_rv[head] = 1'b1;
    check("vr_ready", 64'(vr_ready), 64'(exp_vr));
    check("r_valid", 64'(r_valid), 64'(exp_rv));
    if (exp_rv != '0) check("r_data", 64'(r_data[head]), 64'(vd));
    check("pkt_cnt", 64'(pkt_cnt), 64'(pkt_m));
    check("err_orphan", 64'(err_orphan), 64'(orph_m));
    for (int j = 0; j < N; j++) begin
      if (r_valid[j] && r_ready[j]) res_log.push_back(j * 2 + int'(r_data[j]));
    end
    hs = busy_m && v[owner_m] && m_tready;
    if (hs) begin
      if (fb_m) begin
        for (int j = 0; j < N; j++) if (s_tready[j]) own_log.push_back(j);
        fb_m = 1'b0;
      end
      lastb = src[owner_m][0].l;
      void'(src[owner_m].pop_front());
      if (lastb) busy_m = 1'b0;
    end
    g = -1;
    if (!busy_m && !hs && v != '0 && ordq.size() < DEPTH) g = rr_next(v, last_m);
    if (vv && exp_vr) begin
      void'(ordq.pop_front());
      if (script.size() > 0) void'(script.pop_front());
    end
    if (vv && ordq.size() == 0 && !exp_vr && head == 0 && exp_rv == '0) orph_m = orph_m | (exp_vr == 1'b0 && exp_rv == '0 && vv);
    if (g >= 0) begin
      ordq.push_back(g);
      last_m  = g;
      pkt_m   = pkt_m + 32'd1;
      busy_m  = 1'b1;
      owner_m = g;
      fb_m    = 1'b1;
    end
    @(posedge aclk);
    #1;
  endtask

  function automatic bit srcs_busy();
    for (int i = 0; i < N; i++) if (src[i].size() > 0) return 1'b1;
    return busy_m;
  endfunction

  task automatic drain(input string tag, input int max);
    int c = 0;
    while (srcs_busy() && c < max) begin
      cycle();
      c++;
    end
    check(tag, 64'(c < max), 64'd1);
  endtask

  task automatic run_script(input string tag);
    int c = 0;
    while (script.size() > 0 && c < 50) begin
      cycle();
      c++;
    end
    check(tag, 64'(c < 50), 64'd1);
  endtask

  int exp_o[4] = '{0, 1, 0, 1};
  int exp_r[3] = '{1, 2, 3};

  initial begin
    #3;
    do_reset();

    // single requester, 3 beats on req1
    own_log.delete();
    res_log.delete();
    add_pkt(1, 3);
    drain("t1_drain", 50);
    check("t1_owner_cnt", 64'(own_log.size()), 64'd1);
    if (own_log.size() > 0) check("t1_owner", 64'(own_log[0]), 64'd1);
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    script.push_back(1'b1);
    run_script("t1_result");
    check("t1_res_cnt", 64'(res_log.size()), 64'd1);
    if (res_log.size() > 0) check("t1_res", 64'(res_log[0]), 64'd3);

    // both requesters from reset alternate
    do_reset();
    own_log.delete();
    add_pkt(0, 2); add_pkt(0, 2); add_pkt(1, 2); add_pkt(1, 2);
    drain("t2_drain", 80);
    check("t2_owner_cnt", 64'(own_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < own_log.size(); i++) check("t2_order", 64'(own_log[i]), 64'(exp_o[i]));

    // result routing in order 0,1,1 with data 1,0,1
    do_reset();
    own_log.delete();
    res_log.delete();
    add_pkt(0, 1); add_pkt(1, 1); add_pkt(1, 1);
    drain("t3_drain", 50);
    script.push_back(1'b1); script.push_back(1'b0); script.push_back(1'b1);
    run_script("t3_results");
    check("t3_res_cnt", 64'(res_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < res_log.size(); i++) check("t3_res", 64'(res_log[i]), 64'(exp_r[i]));

    // order FIFO full blocks the ninth grant; result backpressure
    do_reset();
    for (int k = 0; k < 9; k++) add_pkt(k % 2, 1);
    repeat (40) cycle();
    check("t4_full_cnt", 64'(pkt_cnt), 64'd8);
    script.push_back(1'b0); script.push_back(1'b1);
    p_rready = 0;
    repeat (5) cycle();
    check("t4_bp_cnt", 64'(pkt_cnt), 64'd8);
    check("t4_bp_script", 64'(script.size()), 64'd2);
    p_rready = 100;
    drain("t4_drain", 40);
    check("t4_after_pop", 64'(pkt_cnt), 64'd9);

    // orphan result on empty FIFO
    do_reset();
    allow_orphan = 1'b1;
    p_vr = 100;
    repeat (3) cycle();
    allow_orphan = 1'b0;
    p_vr = 0;
    repeat (3) cycle();
    check("t5_orphan_sticky", 64'(err_orphan), 64'd1);

    // reset in the middle of a packet
    do_reset();
    add_pkt(1, 4);
    begin
      int c = 0;
      while (src[1].size() > 3 && c < 20) begin cycle(); c++; end
      check("t6_reach_beat2", 64'(c < 20), 64'd1);
    end
    do_reset();
    own_log.delete();
    res_log.delete();
    add_pkt(0, 1); add_pkt(1, 1);
    drain("t6_drain", 30);
    check("t6_owner_cnt", 64'(own_log.size()), 64'd2);
    if (own_log.size() > 0) check("t6_first_grant", 64'(own_log[0]), 64'd0);
    script.push_back(1'b1); script.push_back(1'b1);
    run_script("t6_results");
    if (res_log.size() > 0) check("t6_first_result", 64'(res_log[0]), 64'd1);

    // randomized traffic
    do_reset();
    p_valid = 70; p_mready = 60; p_rready = 60; p_vr = 50;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src[i].size() < 3 && $urandom_range(9) == 0) add_pkt(i, 1 + $urandom_range(3));
      end
      cycle();
    end
    p_vr = 100; p_rready = 100;
    drain("t7_drain", 400);
    repeat (20) cycle();
    check("t7_all_results", 64'(ordq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
